press_timer: RTL and testbench
==============================

# press_timer

Debounced button-press duration meter for the iCE40 board. It takes one raw active-low pmod button, synchronises and debounces it, and measures how long the button is held in whole seconds from the 12 MHz board clock. The result is latched onto the 4 user LEDs. It complements the free-running LED seconds counter: that block turns time into an LED count; this one turns a held input into an LED count of elapsed seconds.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 120000: cycles an input level must be stable to be accepted (10 ms at 12 MHz); must be ≥ 2.
- SEC_CYCLES, 12000000: clock cycles per counted second; must be ≥ 2.

Ports:
- clk, in, 1: 12 MHz system clock.
- rst, in, 1: reset, asynchronous, active-high.
- btn_n, in, 1: raw pmod button, active-low, asynchronous to clk.
- led, out, 4: last measured press duration in seconds, saturating at 15.
- valid, out, 1: single-cycle pulse when led is updated.
- busy, out, 1: high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: two flops on btn_n, both reset to 1 (released). `pressed = ~btn_s`, where btn_s is the second flop. All FSM decisions use btn_s only.
- Counters:
  - db_cnt: debounce counter, wide enough for DEBOUNCE_CYCLES-1.
  - pre_cnt: prescaler, wide enough for SEC_CYCLES-1.
  - sec: 4-bit seconds count.
- FSM states are IDLE, DB_PRESS, TIMING and DB_RELEASE.
  - IDLE: if pressed, go to DB_PRESS and set db_cnt=0.
  - DB_PRESS:
    - If released, return to IDLE. This is a glitch; outputs are unchanged.
    - Otherwise, if db_cnt==DEBOUNCE_CYCLES-1, go to TIMING and set pre_cnt=0, sec=0.
    - Otherwise, increment db_cnt.
  - TIMING: the prescaler runs. If released, go to DB_RELEASE and set db_cnt=0.
  - DB_RELEASE: the prescaler keeps running.
    - If pressed, go back to TIMING. This is a release bounce; timing is not lost.
    - Otherwise, if db_cnt==DEBOUNCE_CYCLES-1, go to IDLE and latch led <= sec (including any tick occurring in that same cycle), with valid=1 for that cycle.
    - Otherwise, increment db_cnt.
- Prescaler rule, in TIMING and DB_RELEASE:
  - If pre_cnt==SEC_CYCLES-1, then pre_cnt <= 0 and sec <= (sec==15) ? 15 : sec+1.
  - Otherwise, pre_cnt <= pre_cnt+1.
- Result: led = min(15, floor(T / SEC_CYCLES)), where T is the number of cycles spent in TIMING plus DB_RELEASE.
- led holds its value between measurements. A glitch rejected in DB_PRESS never changes led or pulses valid.
- busy = (state != IDLE).

## Timing
- Reset values: led=0, valid=0, busy=0, state=IDLE, db_cnt=0, pre_cnt=0, sec=0, sync flops=1.
- Reset asserted at any time, including mid-TIMING, returns to IDLE immediately. It sets led=0 and produces no valid pulse.
- Input latency: a btn_n edge reaches btn_s 2 clk edges later.
- Press acceptance: the first cycle with pressed in IDLE moves to DB_PRESS. TIMING is entered after exactly DEBOUNCE_CYCLES further consecutive pressed cycles in DB_PRESS.
- Release acceptance: valid asserts in the cycle where DB_RELEASE sees its DEBOUNCE_CYCLES-th consecutive released sample. led is updated on the same edge that raises valid.
- Release debounce time counts toward T. It is therefore fixed overhead of DEBOUNCE_CYCLES cycles, intentional and negligible at 10 ms.
- valid is registered, exactly 1 cycle wide, and never asserted in consecutive cycles.
- A new press while the result is displayed starts a new measurement. led keeps the old value until the next valid.
- pressed and released cannot be simultaneous. Priority in DB_PRESS and DB_RELEASE is the level check first, then terminal count.

## Test plan
All tests use DEBOUNCE_CYCLES=4 and SEC_CYCLES=10.
- Reset: after rst, with btn_n=1, idle for 50 cycles -> led=0, valid=0, busy=0 throughout.
- Glitch: btn_n low for 3 cycles, then high -> busy pulses, valid never asserts, led stays 0, FSM returns to IDLE.
- Normal press: btn_n low long enough for T=35 (TIMING 31 cycles + DB_RELEASE 4) -> one valid pulse with led=3, busy then falls.
- Release bounce: in TIMING, release 2 cycles, press 10 more, then release cleanly with total T=47 -> exactly one valid with led=4.
- Saturation: hold for T=200 -> led=15, one valid. A second press with T=12 -> led=1.
- Reset mid-operation: rst asserted while in TIMING with sec=2 -> led=0, busy=0 immediately, no valid. The next clean press with T=25 -> led=2.

Source files
------------

// File: rtl/press_timer.sv
// Debounced button-press duration meter: measures how long an active-low
// button is held, in whole seconds, and latches the result onto 4 LEDs.
module press_timer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SEC_CYCLES      = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic [3:0] led,
  output logic       valid,
  output logic       busy
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PRE_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SEC_CYCLES - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] DB_PRESS   = 2'd1;
  localparam logic [1:0] TIMING     = 2'd2;
  localparam logic [1:0] DB_RELEASE = 2'd3;

  logic             btn_s1_q, btn_s_q;
  logic [1:0]       state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]       sec_q, sec_d;
  logic [3:0]       led_q, led_d;
  logic             valid_q, valid_d;
  logic             pressed;
  logic             running;

  // Two-flop synchroniser; both stages reset to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= 1'b1;
      btn_s_q  <= 1'b1;
    end else begin
      btn_s1_q <= btn_n;
      btn_s_q  <= btn_s1_q;
    end
  end

  assign pressed = ~btn_s_q;
  assign running = (state_q == TIMING) || (state_q == DB_RELEASE);

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    pre_cnt_d = pre_cnt_q;
    sec_d     = sec_q;
    led_d     = led_q;
    valid_d   = 1'b0;

    // The release debounce window still counts toward the measured time.
    if (running) begin
      if (pre_cnt_q == PRE_LAST) begin
        pre_cnt_d = '0;
        sec_d     = (sec_q == 4'd15) ? 4'd15 : sec_q + 4'd1;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = TIMING;
          pre_cnt_d = '0;
          sec_d     = 4'd0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      TIMING: begin
        if (!pressed) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
        end
      end
      DB_RELEASE: begin
        if (pressed) begin
          state_d = TIMING;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
          led_d   = sec_d;
          valid_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      pre_cnt_q <= '0;
      sec_q     <= 4'd0;
      led_q     <= 4'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      sec_q     <= sec_d;
      led_q     <= led_d;
      valid_q   <= valid_d;
    end
  end

  // valid is a one-cycle strobe with no ready: it rises on the same edge that
  // updates led, and led then holds until the next strobe.
  assign led   = led_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_press_timer.sv
// Scoreboard bench for press_timer with DEBOUNCE_CYCLES=4, SEC_CYCLES=10:
// each press pushes its expected LED value; a monitor pops on every valid.
module tb_press_timer;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic [3:0] led;
  logic       valid;
  logic       busy;

  logic [3:0] exp_q[$];
  int         n_checks;
  int         n_fail;
  logic       prev_valid;

  press_timer #(
    .DEBOUNCE_CYCLES(4),
    .SEC_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .led(led),
    .valid(valid),
    .busy(busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares led against the scoreboard whenever valid is seen.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("led_on_valid", int'(led), int'(exp_q.pop_front()));
        end
        check("valid_single_cycle", int'(prev_valid), 0);
      end
      prev_valid <= valid;
    end
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle_timeout"}, int'(k >= 300), 0);
    repeat (4) @(negedge clk);
  endtask

  // Driver: hold btn_n low for exactly `cycles` clock edges.
  task automatic press(input int cycles, input logic [3:0] exp_led, input string name);
    exp_q.push_back(exp_led);
    btn_n = 1'b0;
    repeat (cycles) @(negedge clk);
    btn_n = 1'b1;
    wait_idle(name);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_led_hold"}, int'(led), int'(exp_led));
    check({name, "_busy_low"}, int'(busy), 0);
  endtask

  initial begin
    logic saw_busy;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    btn_n    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_led", int'(led), 0);
      check("idle_valid", int'(valid), 0);
      check("idle_busy", int'(busy), 0);
    end

    // Glitch of 3 cycles is rejected in DB_PRESS
    saw_busy = 1'b0;
    btn_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    btn_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    check("glitch_busy_pulsed", int'(saw_busy), 1);
    check("glitch_busy_low", int'(busy), 0);
    check("glitch_led", int'(led), 0);

    // Normal press, T=35
    press(35, 4'd3, "normal");

    // Release bounce: T = 30 + 2 + 10 + 5 = 47
    exp_q.push_back(4'd4);
    btn_n = 1'b0;
    repeat (35) @(negedge clk);
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    btn_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_n = 1'b1;
    wait_idle("bounce");
    check("bounce_pending", exp_q.size(), 0);
    check("bounce_led", int'(led), 4);

    // Saturation, then a short press
    press(200, 4'd15, "saturate");
    press(12, 4'd1, "short");

    // Reset while timing (about 2 s elapsed)
    btn_n = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(valid), 0);
    btn_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_led", int'(led), 0);

    press(25, 4'd2, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
